// File: rtl/dmem_responder.sv
// MEM-stage data memory with fixed access latency.
// Byte/half/word loads and stores with sign or zero extension.
module dmem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        re,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [AW+1:0] a_q;
  logic [2:0]    f3_q;
  logic [31:0]   d_q;
  logic          st_q;

  logic [31:0] mem [MEM_WORDS];

  logic          mis;
  logic          legal;
  logic          req;
  logic          accept;
  logic          reject;
  logic          fire;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   word;
  logic [31:0]   ld;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  // upper address bits alias onto the same words
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  always_comb begin
    mis = 1'b0;
    unique case (funct3[1:0])
      2'b01:   mis = addr[0];
      2'b10:   mis = |addr[1:0];
      default: mis = 1'b0;
    endcase
    if (we) begin
      legal = !funct3[2] && (funct3[1:0] != 2'b11);
    end else begin
      legal = (funct3[1:0] != 2'b11) &&
              !(funct3[2] && funct3[1]);
    end
    legal = legal && !mis;
  end

  assign req    = we | re;
  assign accept = (state != WAIT) && req && legal;
  assign reject = (state != WAIT) && req && !legal;
  assign fire   = (state == WAIT) && (cnt == '0);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = accept ? WAIT : IDLE;
      WAIT:       if (fire) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  assign idx = a_q[AW+1:2];

  always_comb begin
    be    = 4'b1111;
    wlane = d_q;
    unique case (1'b1)
      f3_q[1:0] == 2'b00: begin
        be    = 4'b0001 << a_q[1:0];
        wlane = {4{d_q[7:0]}};
      end
      f3_q[1:0] == 2'b01: begin
        be    = a_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{d_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = d_q;
      end
    endcase
  end

  always_comb begin
    word   = mem[idx];
    byte_v = word[{a_q[1:0], 3'b000} +: 8];
    half_v = a_q[1] ? word[31:16] : word[15:0];
    unique case (f3_q[1:0])
      2'b00:   ld = {{24{byte_v[7] & ~f3_q[2]}}, byte_v};
      2'b01:   ld = {{16{half_v[15] & ~f3_q[2]}}, half_v};
      default: ld = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      err   <= reject;
      if (accept) begin
        cnt <= CW'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (fire && !st_q) begin
        rdata <= ld;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= addr[AW+1:0];
      f3_q <= funct3;
      d_q  <= wdata;
      st_q <= we;
    end
  end

  // gated by nrst so a reset during WAIT drops the store
  always_ff @(posedge clk) begin
    if (nrst && fire && st_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign busy = (state == WAIT);
  assign done = (state == DONE);

endmodule
